double_to_unsigned_int: RTL and testbench



---
 rtl/fp64_pkg.sv | 25 ++
 rtl/fp64_class_decode.sv | 47 ++++
 rtl/double_to_unsigned_int.sv | 110 +++++++++++
 tb/tb_double_to_unsigned_int.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fp64_pkg.sv
// fp64_pkg: shared binary64 field constants and the input classification used by
// the double-to-uint64 converter.
//   FP64_BIAS, FP64_EXP_W, FP64_FRAC_W : binary64 field layout
//   UINT64_MAX                         : saturated result
//   fp64_cls_e                         : class of a decoded operand
package fp64_pkg;

  localparam int unsigned FP64_BIAS   = 1023;
  localparam int unsigned FP64_EXP_W  = 11;
  localparam int unsigned FP64_FRAC_W = 52;

  localparam logic [63:0] UINT64_MAX = 64'hFFFF_FFFF_FFFF_FFFF;

  // ClsZero must stay encoded as 0: it is the reset value of every class register.
  typedef enum logic [2:0] {
    ClsZero   = 3'd0,  // +-0, subnormal, or magnitude below 1
    ClsNormal = 3'd1,  // positive, 0 <= e <= 63
    ClsNeg    = 3'd2,  // negative, magnitude >= 1, finite
    ClsOvf    = 3'd3,  // positive, e > 63, finite
    ClsInfPos = 3'd4,
    ClsInfNeg = 3'd5,
    ClsNan    = 3'd6
  } fp64_cls_e;

endpackage

// File: rtl/fp64_class_decode.sv
// fp64_class_decode: combinational split of a binary64 operand into fields plus a
// class code selecting the converter's result rule.
//   a_i     [63:0]  binary64 operand
//   sign_o          sign bit
//   exp_o   [11:0]  unbiased exponent, signed
//   mant_o  [52:0]  mantissa with the hidden one restored
//   cls_o           operand class (fp64_cls_e)
module fp64_class_decode
  import fp64_pkg::*;
(
  input  logic               [63:0] a_i,
  output logic                      sign_o,
  output logic signed        [11:0] exp_o,
  output logic               [52:0] mant_o,
  output fp64_cls_e                 cls_o
);

  logic [FP64_EXP_W-1:0]  ef;
  logic [FP64_FRAC_W-1:0] frac;
  logic signed [11:0]     e;

  always_comb begin
    sign_o = a_i[63];
    ef     = a_i[62:52];
    frac   = a_i[51:0];
    mant_o = {1'b1, frac};
    e      = $signed({1'b0, ef}) - $signed(12'(FP64_BIAS));
    exp_o  = e;

    // Priority order matters: specials first, then magnitude < 1, then sign.
    if (ef == '1) begin
      if (frac != '0) cls_o = ClsNan;
      else            cls_o = sign_o ? ClsInfNeg : ClsInfPos;
    end else if (ef == '0) begin
      cls_o = ClsZero;
    end else if (e < 12'sd0) begin
      cls_o = ClsZero;
    end else if (sign_o) begin
      cls_o = ClsNeg;
    end else if (e > 12'sd63) begin
      cls_o = ClsOvf;
    end else begin
      cls_o = ClsNormal;
    end
  end

endmodule

// File: rtl/double_to_unsigned_int.sv
// double_to_unsigned_int: pipelined binary64 -> uint64 conversion, truncating toward
// zero, saturating out-of-range and special inputs. Latency 3, throughput 1/cycle.
//   clk      rising-edge clock
//   rst      synchronous active-high reset, flushes the pipeline to zero
//   a        binary64 operand, sampled every edge
//   z        unsigned result
//   invalid  NaN / overflow / negative >= 1 flag (only with DOUBLE_TO_UINT_FLAGS_EN)
module double_to_unsigned_int
  import fp64_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] a,
  output logic [63:0] z
`ifdef DOUBLE_TO_UINT_FLAGS_EN
  ,
  output logic        invalid
`endif
);

  // S1: operand register and field decode
  logic [63:0] a_d, a_q;

  logic               dec_sign_d, dec_sign_q;
  logic signed [11:0] dec_exp_d,  dec_exp_q;
  logic        [52:0] dec_mant_d, dec_mant_q;
  fp64_cls_e          dec_cls_d,  dec_cls_q;

  fp64_class_decode u_decode (
    .a_i    (a_q),
    .sign_o (dec_sign_d),
    .exp_o  (dec_exp_d),
    .mant_o (dec_mant_d),
    .cls_o  (dec_cls_d)
  );

  // S2: barrel shift
  logic [63:0] sh_val_d,  sh_val_q;
  fp64_cls_e   sh_cls_d,  sh_cls_q;
  logic        sh_sign_d, sh_sign_q;
  logic [11:0] lsh, rsh;
  logic [63:0] mant64;

  // S3: result select
  logic [63:0] z_d, z_q;
`ifdef DOUBLE_TO_UINT_FLAGS_EN
  logic        invalid_d, invalid_q;
`endif

  always_comb begin
    a_d = a;

    // Only the normal class consumes the shift; other classes may shift garbage.
    mant64 = {11'b0, dec_mant_q};
    lsh    = 12'(dec_exp_q - 12'sd52);
    rsh    = 12'(12'sd52 - dec_exp_q);
    if (dec_exp_q >= 12'sd52) sh_val_d = mant64 << lsh;
    else                      sh_val_d = mant64 >> rsh;
    sh_cls_d  = dec_cls_q;
    sh_sign_d = dec_sign_q;

    unique case (sh_cls_q)
      ClsNormal:           z_d = sh_val_q;
      ClsOvf, ClsInfPos:   z_d = sh_sign_q ? 64'd0 : UINT64_MAX;
      default:             z_d = 64'd0;
    endcase

`ifdef DOUBLE_TO_UINT_FLAGS_EN
    // Negative operands are invalid unless they truncate to zero (class ClsZero).
    invalid_d = (sh_cls_q == ClsNan) || (sh_cls_q == ClsOvf) || (sh_cls_q == ClsInfPos) ||
                (sh_sign_q && (sh_cls_q != ClsZero));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      dec_sign_q <= 1'b0;
      dec_exp_q  <= '0;
      dec_mant_q <= '0;
      dec_cls_q  <= ClsZero;
      sh_val_q   <= '0;
      sh_cls_q   <= ClsZero;
      sh_sign_q  <= 1'b0;
      z_q        <= '0;
`ifdef DOUBLE_TO_UINT_FLAGS_EN
      invalid_q  <= 1'b0;
`endif
    end else begin
      a_q        <= a_d;
      dec_sign_q <= dec_sign_d;
      dec_exp_q  <= dec_exp_d;
      dec_mant_q <= dec_mant_d;
      dec_cls_q  <= dec_cls_d;
      sh_val_q   <= sh_val_d;
      sh_cls_q   <= sh_cls_d;
      sh_sign_q  <= sh_sign_d;
      z_q        <= z_d;
`ifdef DOUBLE_TO_UINT_FLAGS_EN
      invalid_q  <= invalid_d;
`endif
    end
  end

  assign z = z_q;
`ifdef DOUBLE_TO_UINT_FLAGS_EN
  assign invalid = invalid_q;
`endif

endmodule

// File: tb/tb_double_to_unsigned_int.sv
// Bench for double_to_unsigned_int: directed table, random stream with a mid-stream
// reset, all checked against a real-arithmetic reference delayed by three edges.
module tb_double_to_unsigned_int;

  localparam real TWO63 = 9223372036854775808.0;
  localparam real TWO64 = 18446744073709551616.0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] a   = '0;
  logic [63:0] z;
`ifdef DOUBLE_TO_UINT_FLAGS_EN
  logic        invalid;
`endif

  double_to_unsigned_int dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .z       (z)
`ifdef DOUBLE_TO_UINT_FLAGS_EN
    ,
    .invalid (invalid)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] z;
    logic        inv;
    string       tag;
  } exp_t;

  exp_t pipe[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Truncating conversion from the real value of the operand.
  function automatic exp_t ref_model(input logic [63:0] v, input string tag);
    exp_t e;
    real  r, t;
    e.tag = tag;
    e.z   = '0;
    e.inv = 1'b0;
    if (v[62:52] == 11'h7FF && v[51:0] != 52'd0) begin
      e.inv = 1'b1;
    end else begin
      r = $bitstoreal(v);
      if (r >= TWO64) begin
        e.z   = '1;
        e.inv = 1'b1;
      end else if (r <= -1.0) begin
        e.inv = 1'b1;
      end else if (r >= 1.0) begin
        t = $floor(r);
        if (t >= TWO63) e.z = 64'h8000_0000_0000_0000 + 64'(longint'(t - TWO63));
        else            e.z = 64'(longint'(t));
      end
    end
    return e;
  endfunction

  // Apply one operand for one edge; the entry pushed is what must leave 3 edges later.
  task automatic drive(input logic [63:0] v, input logic r, input exp_t e_in);
    exp_t e;
    exp_t flush;
    a   = v;
    rst = r;
    @(posedge clk);
    if (r) begin
      flush.z   = '0;
      flush.inv = 1'b0;
      flush.tag = "flush";
      pipe      = {flush, flush, flush};
      e.z       = '0;
      e.inv     = 1'b0;
      e.tag     = "in_reset";
    end else begin
      pipe.push_back(e_in);
      e = pipe.pop_front();
    end
    #1;
    check_eq($sformatf("%s/z", e.tag), z, e.z);
`ifdef DOUBLE_TO_UINT_FLAGS_EN
    check_eq($sformatf("%s/invalid", e.tag), {63'b0, invalid}, {63'b0, e.inv});
`endif
  endtask

  task automatic step(input logic [63:0] v, input logic r, input string tag);
    drive(v, r, ref_model(v, tag));
  endtask

  function automatic logic [63:0] rand_operand();
    logic [63:0] v;
    longint      hi, n;
    case ($urandom_range(0, 2))
      0: v = {$urandom, $urandom};
      1: begin
        hi = longint'($urandom_range(0, 2097152));
        n  = (hi == 64'd2097152) ? (hi << 32) : ((hi << 32) | longint'($urandom));
        v  = $realtobits(real'(n));
      end
      default: v = {1'($urandom), 11'($urandom_range(1000, 1090)), $urandom, 20'($urandom)};
    endcase
    return v;
  endfunction

  localparam int NDir = 11;
  logic [63:0] dir_a   [NDir] = '{
    64'h3FF0_0000_0000_0000, 64'h400E_0000_0000_0000, 64'h3FE0_0000_0000_0000,
    64'h43E0_0000_0000_0000, 64'h43EF_FFFF_FFFF_FFFF, 64'h43F0_0000_0000_0000,
    64'hBFF0_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h7FF8_0000_0000_0000,
    64'h7FF0_0000_0000_0000, 64'h0000_0000_0000_0001
  };
  logic [63:0] dir_z   [NDir] = '{
    64'd1, 64'd3, 64'd0,
    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_F800, 64'hFFFF_FFFF_FFFF_FFFF,
    64'd0, 64'd0, 64'd0,
    64'hFFFF_FFFF_FFFF_FFFF, 64'd0
  };
  logic        dir_inv [NDir] = '{0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0};
  string       dir_tag [NDir] = '{
    "one", "three_75", "half", "two63", "max_below_2_64", "two64",
    "neg_one", "neg_zero", "nan", "pos_inf", "subnormal"
  };

  initial begin
    exp_t e;
    step(64'd0, 1'b1, "rst0");
    step(64'd0, 1'b1, "rst1");

    for (int i = 0; i < NDir; i++) begin
      e.z   = dir_z[i];
      e.inv = dir_inv[i];
      e.tag = dir_tag[i];
      drive(dir_a[i], 1'b0, e);
    end

    for (int i = 0; i < 1000; i++) begin
      if (i == 500 || i == 501) step(rand_operand(), 1'b1, "mid_rst");
      else                      step(rand_operand(), 1'b0, $sformatf("rnd%0d", i));
    end

    // Post-reset alignment: first real result must belong to the first post-reset input.
    step(64'd0, 1'b1, "rst_a");
    step(64'h4059_0000_0000_0000, 1'b0, "post_rst_100");
    step(64'h4000_0000_0000_0000, 1'b0, "post_rst_2");
    for (int i = 0; i < 3; i++) step(64'd0, 1'b0, "drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time %0t reached, limit 2000000", $time);
    $fatal(1);
  end

endmodule
